// File: rtl/fpu_dispatch_pkg.sv
// Types shared by the FP dispatch stage and its
// destination decoder.
package fpu_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      WB
   } fpu_dispatch_state_t;

   typedef enum logic [1:0] {
      FREG = 2'd0,
      IREG = 2'd1,
      MEM  = 2'd2
   } fpu_wb_dest_t;

   typedef struct packed {
      logic fadd;
      logic fsub;
      logic fmul;
      logic fdiv;
      logic fsqrt;
      logic fsgnj;
      logic fsgnjn;
      logic fsgnjx;
      logic fcvtsw;
      logic fmvwx;
      logic fcvtws;
      logic fmvxw;
      logic feq;
      logic fle;
      logic flw;
      logic fsw;
   } fp_flags_t;

   typedef struct packed {
      fp_flags_t   flags;
      logic [4:0]  rd;
      logic [11:0] imm;
   } instructions;

   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
   } regvpair;

endpackage

// File: rtl/fpu_dispatch_dest.sv
// Maps a decoded FP instruction to its writeback
// target; shared with the hazard logic.
module fpu_dest_decode
   import fpu_dispatch_pkg::*;
(
   input  instructions  instr,
   output fpu_wb_dest_t dest,
   output logic         legal
);

   logic to_freg;
   logic to_ireg;
   logic to_mem;

   always_comb begin
      to_freg = instr.flags.fadd
              | instr.flags.fsub
              | instr.flags.fmul
              | instr.flags.fdiv
              | instr.flags.fsqrt
              | instr.flags.fsgnj
              | instr.flags.fsgnjn
              | instr.flags.fsgnjx
              | instr.flags.fcvtsw
              | instr.flags.fmvwx;
      to_ireg = instr.flags.fcvtws
              | instr.flags.fmvxw
              | instr.flags.feq
              | instr.flags.fle;
      to_mem  = instr.flags.flw
              | instr.flags.fsw;
      legal   = to_freg | to_ireg | to_mem;
      dest    = FREG;
      priority case (1'b1)
         to_freg: dest = FREG;
         to_ireg: dest = IREG;
         to_mem:  dest = MEM;
         default: dest = FREG;
      endcase
   end

endmodule

// File: rtl/fpu_dispatch.sv
// Dispatch stage in front of the FPU: capture, issue,
// wait for completion and hand the result downstream.
module fpu_dispatch
   import fpu_dispatch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  instructions req_instr,
   input  regvpair     req_register,
   input  regvpair     req_fregister,
   output logic        fpu_enabled,
   output instructions fpu_instr,
   output regvpair     fpu_register,
   output regvpair     fpu_fregister,
   input  logic        fpu_completed,
   input  logic [31:0] fpu_result,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [1:0]  wb_dest,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic        illegal_op,
   output logic        timeout_err
);

   fpu_dispatch_state_t state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   instructions         instr_q, instr_d;
   regvpair             reg_q, reg_d;
   regvpair             freg_q, freg_d;
   logic                fpu_en_q, fpu_en_d;
   logic                wb_valid_q, wb_valid_d;
   fpu_wb_dest_t        wb_dest_q, wb_dest_d;
   logic [4:0]          wb_rd_q, wb_rd_d;
   logic [31:0]         wb_data_q, wb_data_d;
   logic                illegal_q, illegal_d;
   logic                timeout_q, timeout_d;

   instructions         dec_in;
   fpu_wb_dest_t        dec_dest;
   logic                dec_legal;

   // WAIT never accepts, so one decoder serves both
   // the legality check and the result tagging.
   assign dec_in = (state_q == WAIT) ? instr_q
                                     : req_instr;

   fpu_dest_decode u_dec (
      .instr (dec_in),
      .dest  (dec_dest),
      .legal (dec_legal)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      instr_d    = instr_q;
      reg_d      = reg_q;
      freg_d     = freg_q;
      fpu_en_d   = 1'b0;
      wb_valid_d = wb_valid_q;
      wb_dest_d  = wb_dest_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      illegal_d  = 1'b0;
      timeout_d  = timeout_q;
      req_ready  = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (fpu_completed) begin
               wb_data_d  = fpu_result;
               wb_dest_d  = dec_dest;
               wb_rd_d    = instr_q.rd;
               wb_valid_d = 1'b1;
               state_d    = WB;
            end else if (cnt_q ==
                  CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WB: begin
            if (wb_ready) begin
               req_ready  = 1'b1;
               wb_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (req_ready && req_valid) begin
         instr_d = req_instr;
         reg_d   = req_register;
         freg_d  = req_fregister;
         if (dec_legal) begin
            fpu_en_d = 1'b1;
            state_d  = ISSUE;
         end else begin
            illegal_d = 1'b1;
            state_d   = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         instr_q    <= '0;
         reg_q      <= '0;
         freg_q     <= '0;
         fpu_en_q   <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_dest_q  <= FREG;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         instr_q    <= instr_d;
         reg_q      <= reg_d;
         freg_q     <= freg_d;
         fpu_en_q   <= fpu_en_d;
         wb_valid_q <= wb_valid_d;
         wb_dest_q  <= wb_dest_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
      end
   end

   assign fpu_enabled   = fpu_en_q;
   assign fpu_instr     = instr_q;
   assign fpu_register  = reg_q;
   assign fpu_fregister = freg_q;
   assign wb_valid      = wb_valid_q;
   assign wb_dest       = wb_dest_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign busy          = (state_q != IDLE);
   assign illegal_op    = illegal_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: directed scenarios plus a
// random run against a transaction-level model.
module tb_fpu_dispatch;
   import fpu_dispatch_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   instructions req_instr;
   regvpair     req_register;
   regvpair     req_fregister;
   logic        fpu_enabled;
   instructions fpu_instr;
   regvpair     fpu_register;
   regvpair     fpu_fregister;
   logic        fpu_completed;
   logic [31:0] fpu_result;
   logic        wb_valid;
   logic        wb_ready;
   logic [1:0]  wb_dest;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        busy;
   logic        illegal_op;
   logic        timeout_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fpu_dispatch #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_instr     (req_instr),
      .req_register  (req_register),
      .req_fregister (req_fregister),
      .fpu_enabled   (fpu_enabled),
      .fpu_instr     (fpu_instr),
      .fpu_register  (fpu_register),
      .fpu_fregister (fpu_fregister),
      .fpu_completed (fpu_completed),
      .fpu_result    (fpu_result),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_dest       (wb_dest),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .busy          (busy),
      .illegal_op    (illegal_op),
      .timeout_err   (timeout_err)
   );

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // op index: 0..9 float dest, 10..13 int dest,
   // 14..15 memory, -1 no FP flag at all
   function automatic int cls_of(input int op);
      if (op < 10) return 0;
      if (op < 14) return 1;
      return 2;
   endfunction

   function automatic instructions mk(input int op,
         input logic [4:0] rd, input logic [11:0] imm);
      instructions i;
      i = '0;
      i.rd = rd;
      i.imm = imm;
      if (op >= 0) i.flags = fp_flags_t'(16'h8000 >> op);
      return i;
   endfunction

   int drv_op = -1;

   // FPU stub
   bit          armed = 0;
   bit          noise_en = 0;
   bit          rand_res = 0;
   int          left = 0;
   int          lat_cfg = 0;
   logic [31:0] res_cfg = '0;
   logic [31:0] res_cur = '0;

   always @(negedge clk) begin
      fpu_completed = 1'b0;
      if (!rstn) begin
         armed = 0;
      end else if (armed) begin
         if (left == 0) begin
            fpu_completed = 1'b1;
            fpu_result = res_cur;
            armed = 0;
         end else begin
            left--;
         end
      end else if (noise_en && $urandom_range(9) == 0) begin
         fpu_completed = 1'b1;
         fpu_result = $urandom;
      end
      if (rstn && fpu_enabled) begin
         armed = 1;
         left = lat_cfg;
         res_cur = rand_res ? $urandom : res_cfg;
      end
   end

   // Transaction-level model: age counts cycles since a
   // legal accept (1 = issue cycle, 2.. = waiting).
   int          m_age = 0;
   bit          m_wb = 0;
   int          m_op = -1;
   instructions m_instr = '0;
   regvpair     m_reg = '0;
   regvpair     m_freg = '0;
   logic        m_en = 0;
   logic        m_ill = 0;
   logic        m_to = 0;
   logic [31:0] m_data = '0;
   logic [1:0]  m_dest = '0;
   logic [4:0]  m_rd = '0;

   always @(posedge clk or negedge rstn) begin : mdl
      bit rdy;
      bit acc;
      if (!rstn) begin
         m_age = 0; m_wb = 0; m_op = -1;
         m_instr = '0; m_reg = '0; m_freg = '0;
         m_en = 0; m_ill = 0; m_to = 0;
         m_data = '0; m_dest = '0; m_rd = '0;
      end else begin
         rdy = (m_age == 0 && !m_wb) || (m_wb && wb_ready);
         acc = rdy && req_valid;
         m_en = 0;
         m_ill = 0;
         if (m_age == 1) begin
            m_age = 2;
         end else if (m_age >= 2) begin
            if (fpu_completed) begin
               m_wb = 1;
               m_age = 0;
               m_data = fpu_result;
               m_dest = 2'(cls_of(m_op));
               m_rd = m_instr.rd;
            end else if (m_age - 1 == TO) begin
               m_to = 1;
               m_age = 0;
            end else begin
               m_age++;
            end
         end else if (m_wb && wb_ready) begin
            m_wb = 0;
         end
         if (acc) begin
            m_instr = req_instr;
            m_reg = req_register;
            m_freg = req_fregister;
            m_op = drv_op;
            if (drv_op >= 0) begin
               m_age = 1;
               m_en = 1;
            end else begin
               m_ill = 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("req_ready", 64'(req_ready),
          64'((m_age == 0 && !m_wb) || (m_wb && wb_ready)));
      chk("busy", 64'(busy), 64'(m_age > 0 || m_wb));
      chk("fpu_en", 64'(fpu_enabled), 64'(m_en));
      chk("illegal", 64'(illegal_op), 64'(m_ill));
      chk("timeout", 64'(timeout_err), 64'(m_to));
      chk("wb_valid", 64'(wb_valid), 64'(m_wb));
      chk("fpu_instr", 64'(fpu_instr), 64'(m_instr));
      chk("fpu_reg", 64'(fpu_register), 64'(m_reg));
      chk("fpu_freg", 64'(fpu_fregister), 64'(m_freg));
      if (m_wb || !rstn) begin
         chk("wb_data", 64'(wb_data), 64'(m_data));
         chk("wb_dest", 64'(wb_dest), 64'(m_dest));
         chk("wb_rd", 64'(wb_rd), 64'(m_rd));
      end
   end

   task automatic send(input int op, input logic [4:0] rd,
         input logic [11:0] imm,
         input logic [31:0] r1, input logic [31:0] r2,
         input logic [31:0] f1, input logic [31:0] f2);
      drv_op = op;
      req_instr = mk(op, rd, imm);
      req_register = '{r1, r2};
      req_fregister = '{f1, f2};
      req_valid = 1'b1;
   endtask

   task automatic wait_wb(input string nm);
      int n;
      n = 0;
      while (!wb_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(wb_valid), 64'd1);
   endtask

   initial begin
      rstn = 1'b0;
      req_valid = 1'b0;
      req_instr = '0;
      req_register = '0;
      req_fregister = '0;
      wb_ready = 1'b0;
      fpu_completed = 1'b0;
      fpu_result = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wbv", 64'(wb_valid), 64'd0);
      chk("rst_en", 64'(fpu_enabled), 64'd0);
      chk("rst_to", 64'(timeout_err), 64'd0);
      chk("rst_data", 64'(wb_data), 64'd0);
      chk("rst_instr", 64'(fpu_instr), 64'd0);
      rstn = 1'b1;

      // fadd, completes on the first WAIT cycle
      @(negedge clk);
      lat_cfg = 0;
      res_cfg = 32'h4040_0000;
      send(0, 5'd5, 12'd0, 0, 0,
           32'h3F80_0000, 32'h4000_0000);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t1_en1", 64'(fpu_enabled), 64'd1);
      chk("t1_fadd", 64'(fpu_instr.flags.fadd), 64'd1);
      chk("t1_frs1", 64'(fpu_fregister.rs1),
          64'h3F80_0000);
      @(negedge clk);
      chk("t1_en0", 64'(fpu_enabled), 64'd0);
      chk("t1_wbv_n2", 64'(wb_valid), 64'd0);
      @(negedge clk);
      chk("t1_wbv_n3", 64'(wb_valid), 64'd1);
      chk("t1_dest", 64'(wb_dest), 64'd0);
      chk("t1_data", 64'(wb_data), 64'h4040_0000);
      chk("t1_rd", 64'(wb_rd), 64'd5);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk("t1_idle", 64'(busy), 64'd0);

      // feq, downstream stalls for 4 cycles
      lat_cfg = 1;
      res_cfg = 32'h0000_0001;
      send(12, 5'd9, 12'd0, 0, 0,
           32'h3F80_0000, 32'h3F80_0000);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_wb("t2_wb_seen");
      repeat (4) begin
         chk("t2_wbv", 64'(wb_valid), 64'd1);
         chk("t2_data", 64'(wb_data), 64'd1);
         chk("t2_dest", 64'(wb_dest), 64'd1);
         chk("t2_rdy", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;

      // flw, then fmul accepted in the same cycle as
      // the flw result drains
      lat_cfg = 0;
      res_cfg = 32'h0000_0108;
      send(14, 5'd3, 12'd8, 32'h100, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_wb("t3_wb_seen");
      chk("t3_dest", 64'(wb_dest), 64'd2);
      chk("t3_data", 64'(wb_data), 64'h108);
      chk("t3_rd", 64'(wb_rd), 64'd3);
      wb_ready = 1'b1;
      lat_cfg = 2;
      res_cfg = 32'hC0C0_0000;
      send(2, 5'd7, 12'd0, 0, 0,
           32'h4000_0000, 32'hC040_0000);
      #1;
      chk("t3_b2b_rdy", 64'(req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wb_ready = 1'b0;
      chk("t3_en", 64'(fpu_enabled), 64'd1);
      chk("t3_fmul", 64'(fpu_instr.flags.fmul), 64'd1);
      chk("t3_wbv0", 64'(wb_valid), 64'd0);
      wait_wb("t3_wb2_seen");
      chk("t3_dest2", 64'(wb_dest), 64'd0);
      chk("t3_data2", 64'(wb_data), 64'hC0C0_0000);
      chk("t3_rd2", 64'(wb_rd), 64'd7);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;

      // no FP flag set
      send(-1, 5'd4, 12'd0, 1, 2, 3, 4);
      #1;
      chk("t4_rdy", 64'(req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t4_ill", 64'(illegal_op), 64'd1);
      chk("t4_busy", 64'(busy), 64'd0);
      repeat (3) begin
         @(negedge clk);
         chk("t4_ill0", 64'(illegal_op), 64'd0);
         chk("t4_en0", 64'(fpu_enabled), 64'd0);
         chk("t4_wbv0", 64'(wb_valid), 64'd0);
      end

      // fdiv that never completes
      lat_cfg = 255;
      send(3, 5'd6, 12'd0, 0, 0, 1, 2);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t5_en", 64'(fpu_enabled), 64'd1);
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         chk("t5_wait_busy", 64'(busy), 64'd1);
         chk("t5_wait_to", 64'(timeout_err), 64'd0);
      end
      @(negedge clk);
      chk("t5_to", 64'(timeout_err), 64'd1);
      chk("t5_idle", 64'(busy), 64'd0);
      chk("t5_wbv", 64'(wb_valid), 64'd0);
      repeat (5) @(negedge clk);
      chk("t5_sticky", 64'(timeout_err), 64'd1);

      // async reset while waiting
      send(0, 5'd1, 12'd0, 0, 0, 5, 6);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      #3 rstn = 1'b0;
      #1;
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_wbv", 64'(wb_valid), 64'd0);
      chk("t6_en", 64'(fpu_enabled), 64'd0);
      chk("t6_to", 64'(timeout_err), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      lat_cfg = 0;
      res_cfg = 32'h4040_0000;
      send(0, 5'd2, 12'd0, 0, 0,
           32'h3F80_0000, 32'h4000_0000);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t6_en1", 64'(fpu_enabled), 64'd1);
      repeat (2) @(negedge clk);
      chk("t6_wbv1", 64'(wb_valid), 64'd1);
      chk("t6_data", 64'(wb_data), 64'h4040_0000);
      wb_ready = 1'b1;
      @(negedge clk);

      // random traffic
      noise_en = 1;
      rand_res = 1;
      for (int c = 0; c < 4000; c++) begin
         int op;
         @(negedge clk);
         rstn = ($urandom_range(999) != 0);
         op = int'($urandom_range(16));
         if (op == 16) op = -1;
         send(op, 5'($urandom), 12'($urandom),
              $urandom, $urandom, $urandom, $urandom);
         req_valid = 1'($urandom_range(1));
         wb_ready = ($urandom_range(99) < 60);
         lat_cfg = ($urandom_range(19) == 0)
                 ? 20 : int'($urandom_range(3));
      end
      @(negedge clk);
      req_valid = 1'b0;
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule

// File: doc/fpu_dispatch.md
Name: fpu_dispatch

Overview:
- Control stage directly upstream of the FPU.
- Accepts one decoded FP instruction plus its integer and float operand pairs from decode over a valid/ready handshake.
- Holds operands stable, pulses the FPU enable for exactly one cycle, and collects the FPU result.
- Presents the result downstream, tagged for the float register file, the integer register file, or the memory stage (flw/fsw address).

Parameters:
- TIMEOUT_CYCLES, 16: WAIT cycles allowed before completion is declared lost.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  decode offers an instruction
- req_ready  out  1  dispatch accepts this cycle
- req_instr  in  instructions  decoded instruction struct, including rd field
- req_register  in  regvpair  integer rs1/rs2 values
- req_fregister  in  regvpair  float rs1/rs2 values
- fpu_enabled  out  1  one-cycle start pulse to FPU
- fpu_instr  out  instructions  captured instruction
- fpu_register  out  regvpair  captured integer operands
- fpu_fregister  out  regvpair  captured float operands
- fpu_completed  in  1  FPU done indication
- fpu_result  in  32  FPU result
- wb_valid  out  1  result available downstream
- wb_ready  in  1  downstream accepts
- wb_dest  out  2  0 = freg, 1 = ireg, 2 = mem address
- wb_rd  out  5  destination register
- wb_data  out  32  result / address
- busy  out  1  state != IDLE
- illegal_op  out  1  one-cycle pulse: accepted instruction had no FP flag set
- timeout_err  out  1  sticky: completion never arrived

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE; the timeout counter clears.
  - All outputs are 0: wb_valid, fpu_enabled, illegal_op, timeout_err, wb_data, wb_rd, wb_dest, and all captured structs.
  - Asserting reset mid-operation aborts the operation; nothing is written back.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, capture instr/register/fregister.
    - If any FP flag is set → ISSUE.
    - Otherwise pulse illegal_op next cycle and stay IDLE.
  - ISSUE: fpu_enabled=1 for exactly this cycle; clear the counter; → WAIT.
  - WAIT: fpu_enabled=0.
    - fpu_completed=1 → register fpu_result into wb_data; set wb_dest/wb_rd; → WB.
    - Otherwise increment the counter. When counter == TIMEOUT_CYCLES-1 without completion, set timeout_err and go to IDLE with no writeback.
  - WB: wb_valid=1; wb_data/wb_dest/wb_rd stay stable until wb_ready.
    - wb_ready=1 and req_valid=1 in the same cycle: req_ready=1, the new request is captured, → ISSUE (back-to-back, no IDLE bubble).
    - wb_ready=1 only → IDLE.
    - req_ready=0 while wb_ready=0.
- Latency: accept at cycle N, fpu_enabled at N+1, completion sampled from N+2, wb_valid at N+3 at the earliest.
- fpu_completed is ignored outside WAIT; a stale high level in other states has no effect.
- Captured operands stay constant from ISSUE through the end of WB.
- Destination classification (combinational on captured instr):
  - fadd, fsub, fmul, fdiv, fsqrt, fsgnj, fsgnjn, fsgnjx, fcvtsw, fmvwx → freg (0).
  - fcvtws, fmvxw, feq, fle → ireg (1).
  - flw, fsw → mem (2).
  - None of the above → illegal.
- timeout_err is cleared only by reset.

Decomposition:
- def.sv gains:
  - fpu_dispatch_state_t enum: IDLE, ISSUE, WAIT, WB.
  - fpu_wb_dest_t enum: FREG, IREG, MEM.
- Sub-module fpu_dest_decode (combinational): instructions → {fpu_wb_dest_t dest, legal}. It is reused by the hazard logic.

Test Plan:
- fadd, fregister.rs1=0x3F800000, rs2=0x40000000, FPU model completes on the first WAIT cycle with 0x40400000 → fpu_enabled high for exactly one cycle; wb_valid at N+3; wb_dest=0; wb_data=0x40400000; wb_rd=instr.rd.
- feq with model result 0x00000001; wb_ready held low for 4 cycles → wb_valid and wb_data stable for all 4 cycles; req_ready=0 throughout; dest=1.
- flw with register.rs1=0x100, imm=8, model returns 0x108; during WB, wb_ready=1 and a new fmul request arrives in the same cycle → new request accepted that cycle; fpu_enabled pulses the next cycle; dest=2 for the first result.
- Request with all FP flags clear → accepted; illegal_op pulses one cycle; fpu_enabled never asserts; wb_valid never asserts.
- fdiv with the model never completing, TIMEOUT_CYCLES=16 → timeout_err rises after 16 WAIT cycles, state returns to IDLE, no wb_valid; timeout_err stays set until rstn is pulsed low.
- rstn dropped asynchronously mid-WAIT → busy, wb_valid, fpu_enabled and timeout_err all 0 immediately; after release, a fresh fadd completes normally.
